// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline control unit and its redirect/hold
// sources (EX, CLINT, hold requesters) and consumers (PC, pipeline registers).
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int N_HOLD = 4,
    parameter int CNT_W  = 32
);
    logic              ex_jump_en_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              int_jump_en_i;
    logic [ADDR_W-1:0] int_jump_addr_i;
    logic [N_HOLD-1:0] hold_req_i;
    logic              cnt_clr_i;
    logic              jump_en_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              stall_o;
    logic              flush_o;
    logic              pend_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  ex_jump_en_i, ex_jump_addr_i, int_jump_en_i, int_jump_addr_i,
        input  hold_req_i, cnt_clr_i,
        output jump_en_o, jump_addr_o, stall_o, flush_o, pend_o, stall_cnt_o
    );

    modport master (
        output ex_jump_en_i, ex_jump_addr_i, int_jump_en_i, int_jump_addr_i,
        output hold_req_i, cnt_clr_i,
        input  jump_en_o, jump_addr_o, stall_o, flush_o, pend_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: int/ex redirect arbitration, jumps deferred under hold,
// multi-cycle flush window after each redirect, saturating stall counter.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int N_HOLD       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [3:0]        r_flush_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_next_pend_addr;
    logic [3:0]        w_next_flush_cnt;
    logic              w_hold;
    logic              w_req_any;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_jump_en;
    logic [ADDR_W-1:0] w_jump_addr;
    logic              w_flush;
    logic              w_pend;
    logic              w_stall;

    assign w_hold     = |bus.hold_req_i;
    assign w_req_any  = bus.int_jump_en_i | bus.ex_jump_en_i;
    assign w_req_addr = bus.int_jump_en_i ? bus.int_jump_addr_i : bus.ex_jump_addr_i;

    // Next-state, deferral and redirect/flush strobe decode
    always_comb begin
        w_next_state     = r_state;
        w_next_pend_addr = r_pend_addr;
        w_next_flush_cnt = r_flush_cnt;
        w_issue          = 1'b0;
        w_issue_addr     = '0;
        w_flush          = 1'b0;
        w_jump_en        = 1'b0;
        w_jump_addr      = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_any && !w_hold) begin
                    w_issue      = 1'b1;
                    w_issue_addr = w_req_addr;
                end else if (w_req_any) begin
                    w_next_pend_addr = w_req_addr;
                    w_next_state     = ST_PEND;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PEND: begin
                // A trap arriving on the release cycle goes out directly.
                if (!w_hold) begin
                    w_issue      = 1'b1;
                    w_issue_addr = bus.int_jump_en_i ? bus.int_jump_addr_i : r_pend_addr;
                end else if (bus.int_jump_en_i) begin
                    w_next_pend_addr = bus.int_jump_addr_i;
                end else begin
                    w_next_state = ST_PEND;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (bus.int_jump_en_i && !w_hold) begin
                    w_issue      = 1'b1;
                    w_issue_addr = bus.int_jump_addr_i;
                end else if (bus.int_jump_en_i) begin
                    w_next_pend_addr = bus.int_jump_addr_i;
                    w_next_state     = ST_PEND;
                end else if (!w_hold) begin
                    if (r_flush_cnt <= 4'd1) begin
                        w_next_flush_cnt = 4'd0;
                        w_next_state     = ST_IDLE;
                    end else begin
                        w_next_flush_cnt = r_flush_cnt - 4'd1;
                    end
                end else begin
                    w_next_flush_cnt = r_flush_cnt;
                end
            end
            default: begin
                w_next_state     = ST_IDLE;
                w_next_flush_cnt = 4'd0;
            end
        endcase

        if (w_issue) begin
            w_jump_en   = 1'b1;
            w_jump_addr = w_issue_addr;
            w_flush     = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state     = ST_FLUSH;
                w_next_flush_cnt = FLUSH_RELOAD;
            end else begin
                w_next_state     = ST_IDLE;
                w_next_flush_cnt = 4'd0;
            end
        end else begin
            w_jump_en   = 1'b0;
            w_jump_addr = '0;
        end
    end

    // pend_o flags a jump that is being held over this clock edge
    assign w_pend  = (w_next_state == ST_PEND);
    assign w_stall = w_hold | w_pend;

    // Control state, deferred target and flush down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pend_addr <= '0;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_pend_addr <= w_next_pend_addr;
            r_flush_cnt <= w_next_flush_cnt;
        end
    end

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.jump_en_o   = w_jump_en;
    assign bus.jump_addr_o = w_jump_addr;
    assign bus.flush_o     = w_flush;
    assign bus.pend_o      = w_pend;
    assign bus.stall_o     = w_stall;
    assign bus.stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// saturation / async-reset sequences, and random traffic against a model.
module tb_pipe_ctrl;
    localparam int AW = 32;
    localparam int NH = 4;
    localparam int FC = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(AW), .N_HOLD(NH), .CNT_W(CW)) u_if ();

    pipe_ctrl #(.ADDR_W(AW), .N_HOLD(NH), .FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        logic [3:0]  hold;
        logic        ex_en;
        logic [31:0] ex_addr;
        logic        int_en;
        logic [31:0] int_addr;
        logic        clr;
        logic        e_jump;
        logic [31:0] e_addr;
        logic        e_flush;
        logic        e_stall;
        logic        e_pend;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] h, logic ee, logic [31:0] ea, logic ie,
                                logic [31:0] ia, logic c, logic ej, logic [31:0] ead,
                                logic ef, logic es, logic ep, logic [3:0] ec);
        vec_t v;
        v.hold = h; v.ex_en = ee; v.ex_addr = ea; v.int_en = ie; v.int_addr = ia;
        v.clr = c; v.e_jump = ej; v.e_addr = ead; v.e_flush = ef; v.e_stall = es;
        v.e_pend = ep; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] h, logic ee, logic [31:0] ea, logic ie,
                         logic [31:0] ia, logic c);
        u_if.hold_req_i      = h;
        u_if.ex_jump_en_i    = ee;
        u_if.ex_jump_addr_i  = ea;
        u_if.int_jump_en_i   = ie;
        u_if.int_jump_addr_i = ia;
        u_if.cnt_clr_i       = c;
    endtask

    task automatic check_all(string tag, logic ej, logic [31:0] ea, logic ef,
                             logic es, logic ep, logic [3:0] ec);
        chk({tag, ".jump_en"}, 64'(u_if.jump_en_o), 64'(ej));
        chk({tag, ".jump_addr"}, 64'(u_if.jump_addr_o), 64'(ea));
        chk({tag, ".flush"}, 64'(u_if.flush_o), 64'(ef));
        chk({tag, ".stall"}, 64'(u_if.stall_o), 64'(es));
        chk({tag, ".pend"}, 64'(u_if.pend_o), 64'(ep));
        chk({tag, ".cnt"}, 64'(u_if.stall_cnt_o), 64'(ec));
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Reference model: pending flag + remaining unstalled flush cycles
    bit          m_pending;
    logic [31:0] m_pend_addr;
    int          m_flush_rem;
    int          m_cnt;

    task automatic model_step(input logic [3:0] h, input logic ee, input logic [31:0] ea,
                              input logic ie, input logic [31:0] ia, input logic c,
                              output logic ej, output logic [31:0] ead, output logic ef,
                              output logic es, output logic ep, output logic [3:0] ec,
                              output bit n_pending, output logic [31:0] n_pend_addr,
                              output int n_flush_rem, output int n_cnt);
        bit          hold;
        bit          take;
        logic [31:0] a;
        hold = (h != 4'b0000);
        ej = 1'b0; ead = 32'h0; ef = 1'b0; ep = 1'b0;
        n_pending = m_pending; n_pend_addr = m_pend_addr; n_flush_rem = m_flush_rem;
        if (m_pending) begin
            a = ie ? ia : m_pend_addr;
            if (!hold) begin
                ej = 1'b1; ead = a; ef = 1'b1; n_pending = 1'b0; n_flush_rem = FC - 1;
            end else begin
                ep = 1'b1; n_pend_addr = a;
            end
        end else begin
            take = ie || (ee && m_flush_rem == 0);
            a = ie ? ia : ea;
            if (take && !hold) begin
                ej = 1'b1; ead = a; ef = 1'b1; n_flush_rem = FC - 1;
            end else if (take) begin
                ep = 1'b1; n_pending = 1'b1; n_pend_addr = a;
                ef = (m_flush_rem > 0); n_flush_rem = 0;
            end else begin
                ef = (m_flush_rem > 0);
                if (m_flush_rem > 0 && !hold) n_flush_rem = m_flush_rem - 1;
            end
        end
        es = hold || ep;
        ec = 4'(m_cnt);
        if (c) n_cnt = 0;
        else if (es && m_cnt < (1 << CW) - 1) n_cnt = m_cnt + 1;
        else n_cnt = m_cnt;
    endtask

    initial begin
        logic [3:0]  rh;
        logic        ree, rie, rc;
        logic [31:0] rea, ria;
        logic        ej, ef, es, ep;
        logic [31:0] ead;
        logic [3:0]  ec;
        bit          np;
        logic [31:0] npa;
        int          nfr, nc;

        // hold, ex, ex_addr, int, int_addr, clr | jump, addr, flush, stall, pend, cnt
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0));
        tbl.push_back(mk(4'h0, 1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 4'd0));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd0));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0));
        tbl.push_back(mk(4'h2, 1'b1, 32'h200, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd0));
        tbl.push_back(mk(4'h2, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd1));
        tbl.push_back(mk(4'h2, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd2));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b1, 32'h300, 1'b1, 32'h80000004, 1'b0, 1'b1, 32'h80000004, 1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b1, 32'h300, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b1, 32'h400, 1'b0, 32'h0,        1'b0, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h8, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd3));
        tbl.push_back(mk(4'h8, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 4'd4));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd5));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd5));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd5));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd0));
        tbl.push_back(mk(4'h1, 1'b0, 32'h0,   1'b1, 32'h500,      1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd0));
        tbl.push_back(mk(4'h1, 1'b0, 32'h0,   1'b1, 32'h600,      1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 4'd1));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b1, 32'h700,      1'b0, 1'b1, 32'h700,      1'b1, 1'b0, 1'b0, 4'd2));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd2));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd2));
        tbl.push_back(mk(4'h0, 1'b1, 32'h800, 1'b0, 32'h0,        1'b0, 1'b1, 32'h800,      1'b1, 1'b0, 1'b0, 4'd2));
        tbl.push_back(mk(4'h1, 1'b0, 32'h0,   1'b1, 32'h900,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 4'd2));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b1, 32'h900,      1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b1, 32'hA00,      1'b0, 1'b1, 32'hA00,      1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 4'd3));
        tbl.push_back(mk(4'h0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4'd3));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].hold, tbl[i].ex_en, tbl[i].ex_addr, tbl[i].int_en,
                  tbl[i].int_addr, tbl[i].clr);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e_jump, tbl[i].e_addr, tbl[i].e_flush,
                      tbl[i].e_stall, tbl[i].e_pend, tbl[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // Saturation, then clear during a stall
        drive(4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        drive(4'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("sat.cnt", 64'(u_if.stall_cnt_o), 64'd15);
        chk("sat.stall", 64'(u_if.stall_o), 64'd1);
        @(posedge clk); #1;
        u_if.cnt_clr_i = 1'b1;
        @(posedge clk); #1;
        u_if.cnt_clr_i = 1'b0;
        chk("clr.zero", 64'(u_if.stall_cnt_o), 64'd0);
        @(posedge clk); #1;
        chk("clr.inc", 64'(u_if.stall_cnt_o), 64'd1);

        // Asynchronous reset while a jump is deferred
        drive(4'h2, 1'b1, 32'hBEE0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        u_if.ex_jump_en_i = 1'b0;
        @(negedge clk);
        chk("arst.pend_before", 64'(u_if.pend_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst.pend", 64'(u_if.pend_o), 64'd0);
        chk("arst.stall", 64'(u_if.stall_o), 64'd1);
        chk("arst.cnt", 64'(u_if.stall_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        u_if.hold_req_i = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("arst.nojump%0d", k), 64'(u_if.jump_en_o), 64'd0);
            chk($sformatf("arst.noflush%0d", k), 64'(u_if.flush_o), 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic against the reference model
        do_reset();
        m_pending = 1'b0; m_pend_addr = 32'h0; m_flush_rem = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rh  = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'h0;
            ree = ($urandom_range(0, 9) < 3);
            rie = ($urandom_range(0, 9) < 1);
            rc  = ($urandom_range(0, 49) == 0);
            rea = $urandom;
            ria = $urandom;
            drive(rh, ree, rea, rie, ria, rc);
            model_step(rh, ree, rea, rie, ria, rc, ej, ead, ef, es, ep, ec, np, npa, nfr, nc);
            @(negedge clk);
            check_all($sformatf("rnd%0d", cyc), ej, ead, ef, es, ep, ec);
            @(posedge clk);
            m_pending = np; m_pend_addr = npa; m_flush_rem = nfr; m_cnt = nc;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
